// File: rtl/arith_req_arbiter_pkg.sv
// arith_req_arbiter_pkg: opcodes and FSM encoding shared by the
// arithmetic request arbiter and its helpers.
package arith_req_arbiter_pkg;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/arith_req_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker; first set
// request at or above ptr wins, else the lowest set request.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!valid && req[j] && (PW'(j) >= ptr)) begin
        gnt[j] = 1'b1;
        valid  = 1'b1;
      end
    end
    // Wrap-around pass: only reached when nothing at/above ptr.
    for (int j = 0; j < N; j++) begin
      if (!valid && req[j]) begin
        gnt[j] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_req_arbiter.sv
// arith_req_arbiter: round-robin sequencer sharing one registered
// arithmetic unit. Option macro: DIV_ZERO_GUARD_EN.
module arith_req_arbiter
  import arith_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int A_width     = 16,
  parameter int B_width     = 16,
  parameter int OUT_width   = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                         CLK_ARB,
  input  logic                         RST_ARB,
  input  logic [NUM_REQ-1:0]           REQ_IN,
  input  logic [NUM_REQ*A_width-1:0]   A_REQ_IN,
  input  logic [NUM_REQ*B_width-1:0]   B_REQ_IN,
  input  logic [NUM_REQ*2-1:0]         FUN_REQ_IN,
  output logic [NUM_REQ-1:0]           GNT_OUT,
  output logic [NUM_REQ-1:0]           DONE_OUT,
  output logic [OUT_width-1:0]         RESULT_OUT,
  output logic                         CARRY_OUT,
  output logic                         ERR_OUT,
  output logic                         BUSY_OUT,
  output logic [A_width-1:0]           ARITH_A_OUT,
  output logic [B_width-1:0]           ARITH_B_OUT,
  output logic [1:0]                   ARITH_FUN_OUT,
  output logic                         ARITH_EN_OUT,
  input  logic [OUT_width-1:0]         ARITH_RES_IN,
  input  logic                         ARITH_CARRY_IN,
  input  logic                         ARITH_FLAG_IN
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  localparam logic [7:0] TO = 8'(TIMEOUT_CYC);

  state_t state, state_nx;

  logic [PW-1:0]        ptr, win_idx, ptr_nx;
  logic [NUM_REQ-1:0]   pick, win_oh;
  logic                 pick_vld;
  logic [A_width-1:0]   sel_a, a_q;
  logic [B_width-1:0]   sel_b, b_q;
  logic [1:0]           sel_fun, fun_q;
  logic [7:0]           cnt, cnt_inc;
  logic                 timeout, dz;
  logic [OUT_width-1:0] res_q;
  logic                 carry_q, err_q;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req   (REQ_IN),
    .ptr   (ptr),
    .gnt   (pick),
    .valid (pick_vld)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_fun = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_a   = A_REQ_IN[i*A_width +: A_width];
        sel_b   = B_REQ_IN[i*B_width +: B_width];
        sel_fun = FUN_REQ_IN[i*2 +: 2];
        win_idx = PW'(i);
      end
    end
  end

  assign ptr_nx  = (win_idx == LAST) ? '0 : win_idx + 1'b1;
  assign cnt_inc = cnt + 8'd1;
  assign timeout = (cnt_inc == TO);

`ifdef DIV_ZERO_GUARD_EN
  assign dz = (sel_fun == DIV) && (sel_b == '0);
`else
  assign dz = 1'b0;
`endif

  always_ff @(posedge CLK_ARB or posedge RST_ARB) begin
    if (RST_ARB) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (pick_vld) state_nx = dz ? RESP : ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (ARITH_FLAG_IN || timeout) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // GNT is a Mealy output of IDLE; gate it so reset forces it low.
  always_comb begin
    GNT_OUT      = '0;
    DONE_OUT     = '0;
    ARITH_EN_OUT = 1'b0;
    BUSY_OUT     = (state != IDLE);
    unique case (state)
      IDLE:  if (!RST_ARB) GNT_OUT = pick;
      ISSUE: ARITH_EN_OUT = 1'b1;
      WAIT:  ;
      RESP:  DONE_OUT = win_oh;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_ARB or posedge RST_ARB) begin
    if (RST_ARB) begin
      ptr     <= '0;
      win_oh  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      cnt     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (pick_vld) begin
          ptr    <= ptr_nx;
          win_oh <= pick;
          a_q    <= sel_a;
          b_q    <= sel_b;
          fun_q  <= sel_fun;
          if (dz) begin
            res_q   <= '1;
            carry_q <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (ARITH_FLAG_IN) begin
            res_q   <= ARITH_RES_IN;
            carry_q <= ARITH_CARRY_IN;
            err_q   <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (timeout) begin
              res_q   <= '0;
              carry_q <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

  assign RESULT_OUT    = res_q;
  assign CARRY_OUT     = carry_q;
  assign ERR_OUT       = err_q;
  assign ARITH_A_OUT   = a_q;
  assign ARITH_B_OUT   = b_q;
  assign ARITH_FUN_OUT = fun_q;

endmodule
